// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: picks one requesting functional unit per cycle and
// broadcasts its tag/result one cycle later. Define CDB_RR_EN for rotating priority.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int SRC_W   = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_REQ-1:0]       REQ,
    input  logic [NUM_REQ*TAG_W-1:0] TAG_IN,
    input  logic [NUM_REQ*32-1:0]    DATA_IN,
    input  logic                     STALL_IN,
    output logic [NUM_REQ-1:0]       GRANT,
    output logic                     CDB_VALID,
    output logic [TAG_W-1:0]         CDB_TAG,
    output logic [31:0]              CDB_DATA,
    output logic [SRC_W-1:0]         CDB_SRC
);

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] rotated;
    logic [SRC_W-1:0]   ptr;
    logic [SRC_W-1:0]   win_idx;
    logic               win_valid;
    int                 win_off;
    int                 win_sum;

    logic [TAG_W-1:0]   tag_arr  [NUM_REQ];
    logic [31:0]        data_arr [NUM_REQ];

    // Reset and stall both empty the eligible set, so GRANT is zero without a CDB path.
    assign eligible = (RESET || STALL_IN) ? '0 : REQ;

    // Rotating the doubled vector puts the highest-priority unit at bit 0.
    assign rotated = NUM_REQ'({eligible, eligible} >> ptr);

    // NOTE: every combinational output gets a default before any conditional
    // assignment, otherwise the untaken paths would infer latches.
    always_comb begin
        win_valid = 1'b0;
        win_off   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                win_valid = 1'b1;
                win_off   = i;
            end
        end
        win_sum = int'(ptr) + win_off;
        if (win_sum >= NUM_REQ) begin
            win_sum = win_sum - NUM_REQ;
        end
        win_idx = SRC_W'(win_sum);
    end

    always_comb begin
        GRANT = '0;
        if (win_valid) begin
            GRANT[win_idx] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            tag_arr[i]  = TAG_IN[i*TAG_W +: TAG_W];
            data_arr[i] = DATA_IN[i*32 +: 32];
        end
    end

    // NOTE: state uses non-blocking assignments; the payload registers are reset
    // too because consumers may observe CDB_TAG/CDB_DATA right after reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            CDB_VALID <= 1'b0;
            CDB_TAG   <= '0;
            CDB_DATA  <= '0;
            CDB_SRC   <= '0;
        end else if (win_valid) begin
            CDB_VALID <= 1'b1;
            CDB_TAG   <= tag_arr[win_idx];
            CDB_DATA  <= data_arr[win_idx];
            CDB_SRC   <= win_idx;
        end else begin
            CDB_VALID <= 1'b0;
        end
    end

`ifdef CDB_RR_EN
    // Pointer moves just past the winner so the winner becomes lowest priority.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr <= '0;
        end else if (win_valid) begin
            ptr <= (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
        end
    end
`else
    // Fixed priority: the search always starts at unit 0.
    assign ptr = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table followed by
// randomized traffic compared against a behavioural arbitration model.
module tb_cdb_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 6;
    localparam int SRC_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*TAG_W-1:0] tag_in;
    logic [NUM_REQ*32-1:0]    data_in;
    logic                     stall;
    logic [NUM_REQ-1:0]       grant;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [31:0]              cdb_data;
    logic [SRC_W-1:0]         cdb_src;

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .SRC_W(SRC_W)) dut (
        .CLK      (clk),
        .RESET    (rst),
        .REQ      (req),
        .TAG_IN   (tag_in),
        .DATA_IN  (data_in),
        .STALL_IN (stall),
        .GRANT    (grant),
        .CDB_VALID(cdb_valid),
        .CDB_TAG  (cdb_tag),
        .CDB_DATA (cdb_data),
        .CDB_SRC  (cdb_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [3:0]  req;
        logic [3:0]  exp_grant;
        logic        exp_valid;
        logic [1:0]  exp_src;
        logic [5:0]  exp_tag;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs[$];
    logic [5:0]  cur_tag  [NUM_REQ];
    logic [31:0] cur_data [NUM_REQ];

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    int          m_ptr   = 0;
    logic        m_valid = 1'b0;
    logic [1:0]  m_src   = '0;
    logic [5:0]  m_tag   = '0;
    logic [31:0] m_data  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic [3:0] q,
                                input logic [3:0] g, input logic v, input logic [1:0] src,
                                input logic [5:0] t, input logic [31:0] d);
        vec_t x;
        x.rst = r; x.stall = s; x.req = q; x.exp_grant = g;
        x.exp_valid = v; x.exp_src = src; x.exp_tag = t; x.exp_data = d;
        return x;
    endfunction

    task automatic drive(input logic r, input logic s, input logic [3:0] q);
        rst   = r;
        stall = s;
        req   = q;
        for (int i = 0; i < NUM_REQ; i++) begin
            tag_in[i*TAG_W +: TAG_W] = cur_tag[i];
            data_in[i*32 +: 32]      = cur_data[i];
        end
    endtask

    // First unit in the eligible set, scanning from ptr and wrapping; -1 if none.
    function automatic int model_winner(input logic r, input logic s, input logic [3:0] q, input int p);
        if (r || s) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (p + k) % NUM_REQ;
            if (q[idx]) return idx;
        end
        return -1;
    endfunction

    initial begin
        logic [3:0] pend;
        logic       r_s;
        logic       s_s;
        int         w;
        logic [3:0] exp_g;

        rst = 1'b1; stall = 1'b0; req = '0; tag_in = '0; data_in = '0;

        cur_tag[0] = 6'h08; cur_data[0] = 32'hC0DE_0000;
        cur_tag[1] = 6'h09; cur_data[1] = 32'hC0DE_0001;
        cur_tag[2] = 6'h15; cur_data[2] = 32'hDEAD_BEEF;
        cur_tag[3] = 6'h0B; cur_data[3] = 32'hC0DE_0003;

        //                 rst   stall req      grant    v     src    tag     data
        vecs.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0, 6'h00, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0, 6'h00, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0, 6'h00, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 6'h08, 32'hC0DE_0000));
        vecs.push_back(mk(1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 6'h15, 32'hDEAD_BEEF));
`ifdef CDB_RR_EN
        vecs.push_back(mk(1'b0, 1'b0, 4'b1001, 4'b1000, 1'b1, 2'd3, 6'h0B, 32'hC0DE_0003));
`else
        vecs.push_back(mk(1'b0, 1'b0, 4'b1001, 4'b0001, 1'b1, 2'd0, 6'h08, 32'hC0DE_0000));
`endif
        vecs.push_back(mk(1'b0, 1'b0, 4'b1001, 4'b0001, 1'b1, 2'd0, 6'h08, 32'hC0DE_0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 2'd0, 6'h08, 32'hC0DE_0000));
        vecs.push_back(mk(1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 2'd0, 6'h08, 32'hC0DE_0000));
        vecs.push_back(mk(1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 2'd1, 6'h09, 32'hC0DE_0001));
        vecs.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0, 6'h00, 32'h0));
`ifdef CDB_RR_EN
        vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 6'h08, 32'hC0DE_0000));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1110, 4'b0010, 1'b1, 2'd1, 6'h09, 32'hC0DE_0001));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1100, 4'b0100, 1'b1, 2'd2, 6'h15, 32'hDEAD_BEEF));
        vecs.push_back(mk(1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 2'd3, 6'h0B, 32'hC0DE_0003));
`else
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 6'h08, 32'hC0DE_0000));
        end
`endif
        vecs.push_back(mk(1'b1, 1'b0, 4'b0100, 4'b0000, 1'b0, 2'd0, 6'h00, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 6'h15, 32'hDEAD_BEEF));

        foreach (vecs[n]) begin
            @(negedge clk);
            drive(vecs[n].rst, vecs[n].stall, vecs[n].req);
            #1;
            check($sformatf("vec%0d grant", n), 64'(grant), 64'(vecs[n].exp_grant));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d cdb{v,src,tag,data}", n),
                  64'({cdb_valid, cdb_src, cdb_tag, cdb_data}),
                  64'({vecs[n].exp_valid, vecs[n].exp_src, vecs[n].exp_tag, vecs[n].exp_data}));
        end

        // Randomized traffic: units hold requests until granted; first cycle resets.
        pend = '0;
        for (int k = 0; k < 400; k++) begin
            r_s = (k == 0) || ($urandom_range(0, 99) < 3);
            s_s = ($urandom_range(0, 99) < 20);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 99) < 40)) begin
                    pend[i]     = 1'b1;
                    cur_tag[i]  = 6'($urandom);
                    cur_data[i] = $urandom;
                end
            end
            @(negedge clk);
            drive(r_s, s_s, pend);
            w     = model_winner(r_s, s_s, pend, m_ptr);
            exp_g = (w < 0) ? 4'b0000 : 4'(1 << w);
            #1;
            check($sformatf("rand%0d grant", k), 64'(grant), 64'(exp_g));
            @(posedge clk);
            #1;
            if (r_s) begin
                m_ptr = 0; m_valid = 1'b0; m_src = '0; m_tag = '0; m_data = '0;
            end else if (w >= 0) begin
                m_valid = 1'b1;
                m_src   = 2'(w);
                m_tag   = cur_tag[w];
                m_data  = cur_data[w];
`ifdef CDB_RR_EN
                m_ptr   = (w + 1) % NUM_REQ;
`endif
                pend[w] = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
            check($sformatf("rand%0d cdb{v,src,tag,data}", k),
                  64'({cdb_valid, cdb_src, cdb_tag, cdb_data}),
                  64'({m_valid, m_src, m_tag, m_data}));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
